// File: rtl/carrier_pkg.sv
// carrier_pkg: shared carrier mode encoding and start-value helper
package carrier_pkg;

    localparam int MODE_WIDTH = 2;

    typedef enum logic [MODE_WIDTH-1:0] {
        TRI    = 2'b00,
        SAW_UP = 2'b01,
        SAW_DN = 2'b10,
        RSVD   = 2'b11
    } mode_e;

    // A period starts at Lower rising, except saw-down which starts at Upper falling
    function automatic logic start_rising(mode_e m);
        return m != SAW_DN;
    endfunction

endpackage

// File: rtl/carrier_wave_gen_if.sv
// carrier_wave_gen_if: control, configuration and carrier outputs of the generator
interface carrier_wave_gen_if #(
    parameter int WIDTH  = 16,
    parameter int MODE_W = 2
);
    logic              En;
    logic              CfgLoad;
    logic [WIDTH-1:0]  CfgUpper;
    logic [WIDTH-1:0]  CfgLower;
    logic [WIDTH-1:0]  CfgStep;
    logic [MODE_W-1:0] CfgMode;
    logic [WIDTH-1:0]  Wave;
    logic              Dir;
    logic              PeakPulse;
    logic              TroughPulse;
    logic              CfgPending;
    logic              CfgErr;

    modport master (
        output En, CfgLoad, CfgUpper, CfgLower, CfgStep, CfgMode,
        input  Wave, Dir, PeakPulse, TroughPulse, CfgPending, CfgErr
    );

    modport slave (
        input  En, CfgLoad, CfgUpper, CfgLower, CfgStep, CfgMode,
        output Wave, Dir, PeakPulse, TroughPulse, CfgPending, CfgErr
    );
endinterface

// File: rtl/carrier_step.sv
// carrier_step: next carrier value, direction and turn strobes for one step
module carrier_step
    import carrier_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  mode_e            mode_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] wave_i,
    input  logic [WIDTH-1:0] upper_i,
    input  logic [WIDTH-1:0] lower_i,
    input  logic [WIDTH-1:0] step_i,
    output logic [WIDTH:0]   wave_o,
    output logic             dir_o,
    output logic             peak_o,
    output logic             trough_o
);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w, u, l, s, span, sum, room, dif, ex_up, ex_dn;
    logic [WIDTH:0] tri_up, tri_dn, saw_up, saw_dn;
    logic           over, under;

    assign w      = {1'b0, wave_i};
    assign u      = {1'b0, upper_i};
    assign l      = {1'b0, lower_i};
    assign s      = {1'b0, step_i};
    assign span   = u - l;
    assign sum    = w + s;
    assign room   = w - l;
    assign dif    = w - s;
    assign over   = sum > u;
    assign under  = room < s;
    // Overshoot past a limit; only meaningful when over/under is set
    assign ex_up  = sum - u;
    assign ex_dn  = s - room;
    // Reflected/wrapped results, clamped to the limit they would cross
    assign tri_up = (ex_up > span) ? l : u - ex_up;
    assign tri_dn = (ex_dn > span) ? u : l + ex_dn;
    assign saw_up = (ex_up > span + ONE) ? u : l + ex_up - ONE;
    assign saw_dn = (ex_dn > span + ONE) ? l : u + ONE - ex_dn;

    // Pick the result for the active mode; reserved mode behaves as triangle
    always_comb begin
        wave_o   = sum;
        dir_o    = 1'b1;
        peak_o   = 1'b0;
        trough_o = 1'b0;
        if (mode_i == SAW_UP) begin
            wave_o   = over ? saw_up : sum;
            peak_o   = over;
            trough_o = over;
        end else if (mode_i == SAW_DN) begin
            wave_o   = under ? saw_dn : dif;
            dir_o    = 1'b0;
            peak_o   = under;
            trough_o = under;
        end else if (dir_i) begin
            wave_o   = over ? tri_up : sum;
            dir_o    = !over;
            peak_o   = over;
        end else begin
            wave_o   = under ? tri_dn : dif;
            dir_o    = under;
            trough_o = under;
        end
    end

endmodule

// File: rtl/carrier_wave_gen.sv
// carrier_wave_gen: double-buffered PWM carrier with period-boundary config apply
module carrier_wave_gen
    import carrier_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MODE_W = MODE_WIDTH
) (
    input logic               MClk,
    input logic               Rst,
    carrier_wave_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  wave_q, wave_d;
    logic [WIDTH-1:0]  act_u_q, act_u_d, act_l_q, act_l_d, act_s_q, act_s_d;
    logic [WIDTH-1:0]  shd_u_q, shd_u_d, shd_l_q, shd_l_d, shd_s_q, shd_s_d;
    mode_e             act_m_q, act_m_d, shd_m_q, shd_m_d, cfg_mode;
    logic              dir_q, dir_d, peak_q, peak_d, trough_q, trough_d;
    logic              pend_q, pend_d, err_q, err_d;
    logic [WIDTH:0]    step_wave, adv_wave;
    logic              step_dir, step_peak, step_trough, adv_dir;
    logic              cfg_bad, load_ok, apply, keep, start_up;
    logic [MODE_W-1:0] mode_raw;

    assign mode_raw = bus.CfgMode;
    assign cfg_mode = mode_e'(mode_raw);

    carrier_step #(.WIDTH(WIDTH)) u_step (
        .mode_i   (act_m_q),
        .dir_i    (dir_q),
        .wave_i   (wave_q),
        .upper_i  (act_u_q),
        .lower_i  (act_l_q),
        .step_i   (act_s_q),
        .wave_o   (step_wave),
        .dir_o    (step_dir),
        .peak_o   (step_peak),
        .trough_o (step_trough)
    );

    // Validate loads, pick the apply point and decide restart versus continue
    always_comb begin
        cfg_bad  = bus.CfgLower >= bus.CfgUpper || bus.CfgStep == '0 || cfg_mode == RSVD;
        load_ok  = bus.CfgLoad && !cfg_bad;
        adv_wave = bus.En ? step_wave : {1'b0, wave_q};
        adv_dir  = bus.En ? step_dir : dir_q;
        apply    = pend_q && (!bus.En || step_trough);
        keep     = shd_m_q == act_m_q && adv_wave >= {1'b0, shd_l_q} && adv_wave <= {1'b0, shd_u_q};
        start_up = start_rising(shd_m_q);
        wave_d   = (apply && !keep) ? (start_up ? shd_l_q : shd_u_q) : adv_wave[WIDTH-1:0];
        dir_d    = (apply && !keep) ? start_up : adv_dir;
        peak_d   = bus.En && step_peak;
        trough_d = bus.En && step_trough;
        act_u_d  = apply ? shd_u_q : act_u_q;
        act_l_d  = apply ? shd_l_q : act_l_q;
        act_s_d  = apply ? shd_s_q : act_s_q;
        act_m_d  = apply ? shd_m_q : act_m_q;
        shd_u_d  = load_ok ? bus.CfgUpper : shd_u_q;
        shd_l_d  = load_ok ? bus.CfgLower : shd_l_q;
        shd_s_d  = load_ok ? bus.CfgStep : shd_s_q;
        shd_m_d  = load_ok ? cfg_mode : shd_m_q;
        pend_d   = load_ok || (pend_q && !apply);
        err_d    = err_q || (bus.CfgLoad && cfg_bad);
    end

    // State registers; reset wins over any simultaneous load
    always_ff @(posedge MClk) begin
        if (Rst) begin
            wave_q   <= '0;
            dir_q    <= 1'b1;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            act_u_q  <= '1;
            act_l_q  <= '0;
            act_s_q  <= STEP_ONE;
            act_m_q  <= TRI;
            shd_u_q  <= '1;
            shd_l_q  <= '0;
            shd_s_q  <= STEP_ONE;
            shd_m_q  <= TRI;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wave_q   <= wave_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            act_u_q  <= act_u_d;
            act_l_q  <= act_l_d;
            act_s_q  <= act_s_d;
            act_m_q  <= act_m_d;
            shd_u_q  <= shd_u_d;
            shd_l_q  <= shd_l_d;
            shd_s_q  <= shd_s_d;
            shd_m_q  <= shd_m_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign bus.Wave        = wave_q;
    assign bus.Dir         = dir_q;
    assign bus.PeakPulse   = peak_q;
    assign bus.TroughPulse = trough_q;
    assign bus.CfgPending  = pend_q;
    assign bus.CfgErr      = err_q;

endmodule

// File: tb/tb_carrier_wave_gen.sv
// tb_carrier_wave_gen: directed checks of carrier sequences, config apply and errors
module tb_carrier_wave_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    carrier_wave_gen_if #(.WIDTH(16), .MODE_W(2)) bus ();

    carrier_wave_gen #(.WIDTH(16), .MODE_W(2)) dut (
        .MClk (clk),
        .Rst  (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int w, input logic d, input logic p, input logic t);
        tick();
        chk({tag, " wave"}, 32'(bus.Wave), w);
        chk({tag, " dir"}, 32'(bus.Dir), 32'(d));
        chk({tag, " peak"}, 32'(bus.PeakPulse), 32'(p));
        chk({tag, " trough"}, 32'(bus.TroughPulse), 32'(t));
    endtask

    task automatic load(input int l, input int u, input int s, input logic [1:0] m);
        bus.CfgLower = 16'(l);
        bus.CfgUpper = 16'(u);
        bus.CfgStep  = 16'(s);
        bus.CfgMode  = m;
        bus.CfgLoad  = 1'b1;
    endtask

    initial begin
        bus.En = 1'b0;
        bus.CfgLoad = 1'b0;
        bus.CfgLower = '0;
        bus.CfgUpper = '0;
        bus.CfgStep = '0;
        bus.CfgMode = '0;
        tick();
        run("reset", 0, 1, 0, 0);
        chk("reset pending", 32'(bus.CfgPending), 0);
        chk("reset err", 32'(bus.CfgErr), 0);
        rst = 1'b0;
        // triangle L0 U10 S3, applied while disabled
        load(0, 10, 3, 2'b00);
        run("tri load", 0, 1, 0, 0);
        chk("tri load pending", 32'(bus.CfgPending), 1);
        bus.CfgLoad = 1'b0;
        run("tri apply", 0, 1, 0, 0);
        chk("tri apply pending", 32'(bus.CfgPending), 0);
        bus.En = 1'b1;
        run("tri", 3, 1, 0, 0);
        run("tri", 6, 1, 0, 0);
        run("tri", 9, 1, 0, 0);
        run("tri peak", 8, 0, 1, 0);
        run("tri", 5, 0, 0, 0);
        run("tri", 2, 0, 0, 0);
        run("tri trough", 1, 1, 0, 1);
        run("tri", 4, 1, 0, 0);
        // mid-period load of U=20: old limit holds until the trough
        load(0, 20, 3, 2'b00);
        run("mid load", 7, 1, 0, 0);
        chk("mid pending", 32'(bus.CfgPending), 1);
        bus.CfgLoad = 1'b0;
        run("mid land", 10, 1, 0, 0);
        run("mid old peak", 7, 0, 1, 0);
        chk("mid still pending", 32'(bus.CfgPending), 1);
        run("mid", 4, 0, 0, 0);
        run("mid", 1, 0, 0, 0);
        run("mid apply", 2, 1, 0, 1);
        chk("mid applied pending", 32'(bus.CfgPending), 0);
        run("new", 5, 1, 0, 0);
        run("new", 8, 1, 0, 0);
        run("new above old U", 11, 1, 0, 0);
        // rejected loads leave the running sequence alone
        load(10, 5, 3, 2'b00);
        run("bad limits", 14, 1, 0, 0);
        chk("bad limits err", 32'(bus.CfgErr), 1);
        chk("bad limits pending", 32'(bus.CfgPending), 0);
        load(0, 10, 0, 2'b00);
        run("bad step", 17, 1, 0, 0);
        load(0, 10, 3, 2'b11);
        run("bad mode", 20, 1, 0, 0);
        bus.CfgLoad = 1'b0;
        run("bad after", 17, 0, 1, 0);
        chk("err sticky", 32'(bus.CfgErr), 1);
        chk("bad pending", 32'(bus.CfgPending), 0);
        // saw-up L0 U10 S4
        bus.En = 1'b0;
        load(0, 10, 4, 2'b01);
        run("sawup load", 17, 0, 0, 0);
        bus.CfgLoad = 1'b0;
        run("sawup start", 0, 1, 0, 0);
        bus.En = 1'b1;
        run("sawup", 4, 1, 0, 0);
        run("sawup", 8, 1, 0, 0);
        run("sawup wrap", 1, 1, 1, 1);
        run("sawup", 5, 1, 0, 0);
        run("sawup", 9, 1, 0, 0);
        run("sawup wrap", 2, 1, 1, 1);
        // saw-down same limits
        bus.En = 1'b0;
        load(0, 10, 4, 2'b10);
        run("sawdn load", 2, 1, 0, 0);
        bus.CfgLoad = 1'b0;
        run("sawdn start", 10, 0, 0, 0);
        bus.En = 1'b1;
        run("sawdn", 6, 0, 0, 0);
        run("sawdn", 2, 0, 0, 0);
        run("sawdn wrap", 9, 0, 1, 1);
        // oversized step clamps to the limits
        bus.En = 1'b0;
        load(0, 10, 25, 2'b00);
        run("big load", 9, 0, 0, 0);
        bus.CfgLoad = 1'b0;
        run("big start", 0, 1, 0, 0);
        bus.En = 1'b1;
        run("big", 0, 0, 1, 0);
        run("big", 10, 1, 0, 1);
        run("big", 0, 0, 1, 0);
        run("big", 10, 1, 0, 1);
        // disabled: frozen, no strobes
        bus.En = 1'b0;
        run("hold", 10, 1, 0, 0);
        run("hold", 10, 1, 0, 0);
        run("hold", 10, 1, 0, 0);
        bus.En = 1'b1;
        run("resume", 0, 0, 1, 0);
        // reset with a simultaneous load
        rst = 1'b1;
        load(0, 20, 5, 2'b01);
        run("rst", 0, 1, 0, 0);
        chk("rst pending", 32'(bus.CfgPending), 0);
        chk("rst err", 32'(bus.CfgErr), 0);
        rst = 1'b0;
        bus.CfgLoad = 1'b0;
        run("post rst", 1, 1, 0, 0);
        run("post rst", 2, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
